// File: rtl/fp_pkg.sv
// Shared single-precision field widths, rounding-mode encoding and packed result type.
package fp_pkg;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned GRS_W  = 3;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RTZ = 2'b01,
        RM_RDN = 2'b10,
        RM_RUP = 2'b11
    } rm_e;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    function automatic fp32_t fp_pack(input logic sign, input logic [EXP_W-1:0] exp,
                                      input logic [FRAC_W-1:0] frac);
        fp32_t r;
        r.sign = sign;
        r.exp  = exp;
        r.frac = frac;
        return r;
    endfunction

endpackage

// File: rtl/round_decide.sv
// Combinational round-up decision from sign, fraction LSB, guard/round/sticky and rounding mode.
module round_decide
    import fp_pkg::*;
(
    input  logic             sign,
    input  logic             lsb,
    input  logic [GRS_W-1:0] grs,
    input  rm_e              rm,
    output logic             inc,
    output logic             inexact
);

    logic g_bit;
    logic r_bit;
    logic s_bit;

    assign g_bit = grs[2];
    assign r_bit = grs[1];
    assign s_bit = grs[0];

    always_comb begin
        inc     = 1'b0;
        inexact = |grs;
        unique case (rm)
            RM_RNE: inc = g_bit & (r_bit | s_bit | lsb);
            RM_RTZ: inc = 1'b0;
            RM_RDN: inc = sign & (g_bit | r_bit | s_bit);
            RM_RUP: inc = ~sign & (g_bit | r_bit | s_bit);
            default: inc = 1'b0;
        endcase
    end

endmodule

// File: rtl/round_stage.sv
// Two-register rounding stage: stage 1 decides the increment, stage 2 applies it and packs.
module round_stage
    import fp_pkg::*;
#(
    parameter int unsigned FLUSH_DENORM = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sign_in,
    input  logic [FRAC_W-1:0] mant_in,
    input  logic [EXP_W-1:0]  exp_in,
    input  logic [GRS_W-1:0]  grs_in,
    input  logic [1:0]        rm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       result,
    output logic              flag_inexact,
    output logic              flag_overflow
);

    if (FLUSH_DENORM != 1) begin : g_flush_check
        $error("round_stage: FLUSH_DENORM=0 (denormal support) is not implemented");
    end

    // Handshake
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s1_adv;
    logic s2_adv;
    logic s1_load;
    logic s2_load;

    assign s2_adv   = ~s2_valid_q | out_ready;
    assign s1_adv   = ~s1_valid_q | s2_adv;
    assign in_ready = s1_adv;
    assign s1_load  = in_valid & s1_adv;
    assign s2_load  = s1_valid_q & s2_adv;

    // Stage 1
    logic              s1_sign_q,    s1_sign_d;
    logic [FRAC_W-1:0] s1_mant_q,    s1_mant_d;
    logic [EXP_W-1:0]  s1_exp_q,     s1_exp_d;
    logic              s1_inc_q,     s1_inc_d;
    logic              s1_inexact_q, s1_inexact_d;
    logic              dec_inc;
    logic              dec_inexact;

    round_decide u_round_decide (
        .sign    (sign_in),
        .lsb     (mant_in[0]),
        .grs     (grs_in),
        .rm      (rm_e'(rm)),
        .inc     (dec_inc),
        .inexact (dec_inexact)
    );

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_sign_d    = s1_sign_q;
        s1_mant_d    = s1_mant_q;
        s1_exp_d     = s1_exp_q;
        s1_inc_d     = s1_inc_q;
        s1_inexact_d = s1_inexact_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
        end
        if (s1_load) begin
            s1_sign_d    = sign_in;
            s1_mant_d    = mant_in;
            s1_exp_d     = exp_in;
            s1_inc_d     = dec_inc;
            s1_inexact_d = dec_inexact;
        end
    end

    // Stage 2 datapath
    logic [FRAC_W:0]  sum;
    logic [EXP_W-1:0] exp_plus1;
    fp32_t            res_c;
    logic             inexact_c;
    logic             overflow_c;

    assign sum       = {1'b0, s1_mant_q} + {{FRAC_W{1'b0}}, s1_inc_q};
    assign exp_plus1 = s1_exp_q + 8'd1;

    always_comb begin
        res_c      = fp_pack(s1_sign_q, s1_exp_q, sum[FRAC_W-1:0]);
        inexact_c  = s1_inexact_q;
        overflow_c = 1'b0;
        if (s1_exp_q == EXP_MAX) begin
            res_c     = fp_pack(s1_sign_q, EXP_MAX, s1_mant_q);
            inexact_c = 1'b0;
        end else if (s1_exp_q == '0) begin
            res_c     = fp_pack(s1_sign_q, '0, '0);
            inexact_c = 1'b0;
        end else if (sum[FRAC_W]) begin
            // Mantissa wrapped to 1.0 of the next binade; may saturate to infinity.
            res_c = fp_pack(s1_sign_q, exp_plus1, '0);
            if (exp_plus1 == EXP_MAX) begin
                overflow_c = 1'b1;
                inexact_c  = 1'b1;
            end
        end
    end

    fp32_t result_q,   result_d;
    logic  inexact_q,  inexact_d;
    logic  overflow_q, overflow_d;

    always_comb begin
        s2_valid_d = s2_valid_q;
        result_d   = result_q;
        inexact_d  = inexact_q;
        overflow_d = overflow_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
        end
        if (s2_load) begin
            result_d   = res_c;
            inexact_d  = inexact_c;
            overflow_d = overflow_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_mant_q    <= '0;
            s1_exp_q     <= '0;
            s1_inc_q     <= 1'b0;
            s1_inexact_q <= 1'b0;
            s2_valid_q   <= 1'b0;
            result_q     <= '0;
            inexact_q    <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_sign_q    <= s1_sign_d;
            s1_mant_q    <= s1_mant_d;
            s1_exp_q     <= s1_exp_d;
            s1_inc_q     <= s1_inc_d;
            s1_inexact_q <= s1_inexact_d;
            s2_valid_q   <= s2_valid_d;
            result_q     <= result_d;
            inexact_q    <= inexact_d;
            overflow_q   <= overflow_d;
        end
    end

    assign out_valid     = s2_valid_q;
    assign result        = result_q;
    assign flag_inexact  = inexact_q;
    assign flag_overflow = overflow_q;

endmodule

// File: tb/tb_round_stage.sv
// Directed and randomized bench for round_stage against an arithmetic rounding model.
module tb_round_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        sign_in = 1'b0;
    logic [22:0] mant_in = '0;
    logic [7:0]  exp_in = '0;
    logic [2:0]  grs_in = '0;
    logic [1:0]  rm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        flag_inexact;
    logic        flag_overflow;

    always #5 clk = ~clk;

    round_stage #(.FLUSH_DENORM(1)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .sign_in       (sign_in),
        .mant_in       (mant_in),
        .exp_in        (exp_in),
        .grs_in        (grs_in),
        .rm            (rm),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
        .flag_inexact  (flag_inexact),
        .flag_overflow (flag_overflow)
    );

    int          vectors = 0;
    int          miscompares = 0;
    int          popped = 0;
    logic [33:0] sb[$];

    // Expected {result, inexact, overflow} from value-level rounding rules.
    function automatic logic [33:0] ref_model(input logic s, input logic [22:0] m,
                                              input logic [7:0] e, input logic [2:0] g,
                                              input logic [1:0] r);
        int unsigned sig;
        int unsigned ee;
        bit          up;
        bit          nz;
        if (e == 8'hFF) return {s, 8'hFF, m, 2'b00};
        if (e == 8'h00) return {s, 31'b0, 2'b00};
        sig = (1 << 23) + int'(m);
        nz  = (g != 0);
        case (r)
            2'd0:    up = (g > 4) || (g == 4 && (sig % 2) == 1);
            2'd1:    up = 0;
            2'd2:    up = s && nz;
            default: up = !s && nz;
        endcase
        sig = sig + (up ? 1 : 0);
        ee  = e;
        if (sig == (1 << 24)) begin
            ee = ee + 1;
            if (ee == 255) return {s, 8'hFF, 23'b0, 2'b11};
        end
        return {s, ee[7:0], sig[22:0], nz, 1'b0};
    endfunction

    task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic set_in(input logic s, input logic [22:0] m, input logic [7:0] e,
                          input logic [2:0] g, input logic [1:0] r);
        sign_in = s;
        mant_in = m;
        exp_in  = e;
        grs_in  = g;
        rm      = r;
    endtask

    task automatic gen(output logic s, output logic [22:0] m, output logic [7:0] e,
                       output logic [2:0] g, output logic [1:0] r);
        int unsigned pick;
        s    = 1'($urandom);
        g    = 3'($urandom);
        r    = 2'($urandom);
        m    = ($urandom_range(0, 3) == 0) ? 23'h7FFFFF : 23'($urandom);
        pick = $urandom_range(0, 7);
        case (pick)
            0:       e = 8'h00;
            1:       e = 8'hFF;
            2:       e = 8'hFE;
            default: e = 8'($urandom_range(1, 254));
        endcase
    endtask

    task automatic send(input logic s, input logic [22:0] m, input logic [7:0] e,
                        input logic [2:0] g, input logic [1:0] r, input logic [33:0] expv);
        int n = 0;
        set_in(s, m, e, g, r);
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                check("send_timeout", 34'd0, 34'd1);
                break;
            end
        end
        sb.push_back(expv);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", {33'b0, out_valid}, 34'd0);
            end else begin
                check("result", {result, flag_inexact, flag_overflow}, sb.pop_front());
                popped++;
            end
        end
    end

    logic [22:0] bm[4];
    logic [7:0]  be[4];
    logic [2:0]  bg[4];
    logic [1:0]  br[4];
    logic        bs[4];
    logic [33:0] bx[4];

    initial begin
        int idx;
        int sent;
        int pop0;
        bit take;
        logic ts;
        logic [22:0] tm;
        logic [7:0] te;
        logic [2:0] tg;
        logic [1:0] tr;

        // Reset state
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        check("reset_out_valid", {33'b0, out_valid}, 34'd0);
        check("reset_result", {result, flag_inexact, flag_overflow}, 34'd0);
        check("reset_in_ready", {33'b0, in_ready}, 34'd1);

        // RNE tie, with latency check
        send(1'b0, 23'h000001, 8'h80, 3'b100, 2'd0, {32'h40000002, 2'b10});
        check("latency_edge1", {33'b0, out_valid}, 34'd0);
        idle(1);
        check("latency_edge2", {33'b0, out_valid}, 34'd1);
        idle(2);
        send(1'b0, 23'h000002, 8'h80, 3'b100, 2'd0, {32'h40000002, 2'b10});
        // Carry into exponent and overflow to infinity
        send(1'b0, 23'h7FFFFF, 8'h7F, 3'b110, 2'd0, {32'h40000000, 2'b10});
        send(1'b0, 23'h7FFFFF, 8'hFE, 3'b110, 2'd0, {32'h7F800000, 2'b11});
        // Directed modes on a negative operand
        send(1'b1, 23'h000010, 8'h81, 3'b001, 2'd2, {32'hC0800011, 2'b10});
        send(1'b1, 23'h000010, 8'h81, 3'b001, 2'd3, {32'hC0800010, 2'b10});
        send(1'b1, 23'h000010, 8'h81, 3'b001, 2'd1, {32'hC0800010, 2'b10});
        // Special exponents
        send(1'b0, 23'h400000, 8'hFF, 3'b111, 2'd0, {32'h7FC00000, 2'b00});
        send(1'b0, 23'h123456, 8'h00, 3'b101, 2'd3, {32'h00000000, 2'b00});
        idle(4);
        check("directed_drained", 34'(sb.size()), 34'd0);

        // Backpressure: four back-to-back inputs, output stalled for five cycles
        for (int i = 0; i < 4; i++) begin
            gen(bs[i], bm[i], be[i], bg[i], br[i]);
            bx[i] = ref_model(bs[i], bm[i], be[i], bg[i], br[i]);
        end
        pop0 = popped;
        out_ready = 1'b0;
        idx = 0;
        set_in(bs[0], bm[0], be[0], bg[0], br[0]);
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) check("stall_hold", {result, flag_inexact, flag_overflow}, bx[0]);
            if (in_valid && in_ready) begin
                sb.push_back(bx[idx]);
                idx++;
            end
            @(posedge clk);
            #1;
            if (idx < 4) set_in(bs[idx], bm[idx], be[idx], bg[idx], br[idx]);
            else in_valid = 1'b0;
        end
        check("accepts_before_stall", 34'(idx), 34'd2);
        check("in_ready_stalled", {33'b0, in_ready}, 34'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 30 && (idx < 4 || sb.size() != 0); c++) begin
            @(negedge clk);
            if (in_valid && in_ready) begin
                sb.push_back(bx[idx]);
                idx++;
            end
            @(posedge clk);
            #1;
            if (idx < 4) set_in(bs[idx], bm[idx], be[idx], bg[idx], br[idx]);
            else in_valid = 1'b0;
        end
        in_valid = 1'b0;
        check("bp_outputs", 34'(popped - pop0), 34'd4);

        // Reset with both stages full
        out_ready = 1'b0;
        gen(ts, tm, te, tg, tr);
        set_in(ts, tm, te, tg, tr);
        in_valid = 1'b1;
        idle(2);
        in_valid = 1'b0;
        check("full_before_reset", {32'b0, out_valid, in_ready}, {32'b0, 2'b10});
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("midreset_out_valid", {33'b0, out_valid}, 34'd0);
        check("midreset_result", {result, flag_inexact, flag_overflow}, 34'd0);
        check("midreset_in_ready", {33'b0, in_ready}, 34'd1);
        pop0 = popped;
        out_ready = 1'b1;
        idle(8);
        check("no_stale_output", 34'(popped - pop0), 34'd0);

        // Randomized traffic with random backpressure
        sent = 0;
        for (int c = 0; c < 3000 && sent < 400; c++) begin
            if (!in_valid && $urandom_range(0, 3) != 0) begin
                gen(ts, tm, te, tg, tr);
                set_in(ts, tm, te, tg, tr);
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            take = 1'b0;
            @(negedge clk);
            if (in_valid && in_ready) begin
                sb.push_back(ref_model(sign_in, mant_in, exp_in, grs_in, rm));
                sent++;
                take = 1'b1;
            end
            @(posedge clk);
            #1;
            if (take) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 50 && sb.size() != 0; c++) idle(1);
        check("random_drained", 34'(sb.size()), 34'd0);
        check("random_sent", 34'(sent), 34'd400);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
